// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the on-chip initiator and its responders.
//   wb_state_e  : initiator FSM state (IDLE, BUS, RESP)
//   WB_ADDR_W   : default address width
//   WB_DATA_W   : default data width
//   sel_w()     : byte-lane select width for a given data width
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator. Takes one command at a time from a valid/ready
// port, runs a single read or write cycle on the bus, and returns the read
// data (or a timeout error) on a valid/ready response port.
//
// Ports
//   wb_clk_i, wb_rst_ni            bus clock, async active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i           command fields, latched on acceptance
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_dat_o, rsp_err_o           read data (0 for writes/errors), timeout flag
//   wbm_*                          Wishbone initiator signals
//   busy_o                         high whenever a command is in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held on rsp_* until the consumer takes it
module wb_cmd_initiator
  import wb_pkg::*;
#(
  parameter int  ADDR_W  = WB_ADDR_W,
  parameter int  DATA_W  = WB_DATA_W,
  parameter int  TIMEOUT = 255,
  localparam int SEL_W   = sel_w(DATA_W)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,

  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,

  output logic              busy_o
);

  // With TIMEOUT=0 the counter is never compared; one bit keeps it legal.
  localparam int             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  wb_state_e        state_q;
  wb_state_e        state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state logic. Ack is tested first so it wins over a coincident timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (cmd_valid_i) state_nxt = BUS;
      BUS: begin
        if (wbm_ack_i)        state_nxt = RESP;
        else if (timeout_hit) state_nxt = RESP;
      end
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, timeout counter, bus and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cnt_q     <= '0;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
          end else if (timeout_hit) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            // Saturate so an untimed (TIMEOUT=0) wait never wraps.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) rsp_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded directly from state.
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
module tb_wb_cmd_initiator;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, wbm_we, ack = 1'b0, busy;
  logic [31:0] wbm_adr, wbm_dat, wbm_dat_i = '0;
  logic [3:0]  wbm_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wbm_we),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack), .busy_o(busy)
  );

  // Reference model: a responder that acks after `waits` wait states
  // (negative = never) against a bus that gives up after T strobe cycles.
  function automatic void model(input logic we, input int waits, input logic [31:0] rdata,
                                output int exp_stb, output logic [31:0] exp_dat,
                                output logic exp_err);
    if (waits >= 0 && waits + 1 <= T) begin
      exp_stb = waits + 1;
      exp_dat = we ? 32'h0 : rdata;
      exp_err = 1'b0;
    end else begin
      exp_stb = T;
      exp_dat = 32'h0;
      exp_err = 1'b1;
    end
  endfunction

  // Drives one command, acts as the responder, then holds the response for
  // `hold` cycles before consuming it. Returns what was observed.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                        input int hold, input bit poke_cmd, input bit poke_ack,
                        output int stb_n, output int lat, output logic [31:0] r_dat,
                        output logic r_err, output int bus_bad, output int hold_bad,
                        output bit hung);
    bit done;
    int guard;
    stb_n = 0; lat = 0; bus_bad = 0; hold_bad = 0; hung = 0; done = 0; guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    while (!done) begin
      if (rsp_valid) done = 1;
      else begin
        if (stb) begin
          stb_n++;
          if (!cyc || wbm_we !== we || wbm_adr !== adr || wbm_dat !== dat || wbm_sel !== sel)
            bus_bad++;
        end
        ack = (waits >= 0) && stb && (stb_n == waits + 1);
        wbm_dat_i = ack ? rdata : $urandom;
        @(posedge clk);
        lat++;
        @(negedge clk);
        ack = 1'b0;
        guard++;
        if (guard > 200) begin hung = 1; done = 1; end
      end
    end
    r_dat = rsp_dat;
    r_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (poke_cmd) begin
        cmd_valid = 1'b1; cmd_adr = $urandom; cmd_we = 1'(($urandom));
      end
      if (poke_ack) ack = 1'($urandom);
      wbm_dat_i = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== r_dat || rsp_err !== r_err || cmd_ready || stb || cyc)
        hold_bad++;
    end
    cmd_valid = 1'b0;
    ack = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_txn(input string name, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int waits,
                           input logic [31:0] rdata, input int hold, input bit poke_cmd,
                           input bit poke_ack);
    int stb_n, lat, bus_bad, hold_bad, exp_stb;
    logic [31:0] r_dat, exp_dat;
    logic r_err, exp_err;
    bit hung;
    model(we, waits, rdata, exp_stb, exp_dat, exp_err);
    do_txn(we, adr, dat, sel, waits, rdata, hold, poke_cmd, poke_ack,
           stb_n, lat, r_dat, r_err, bus_bad, hold_bad, hung);
    checks++;
    if (hung) begin errors++; $display("FAIL %s hang: no response within 200 cycles", name); end
    checks++;
    if (stb_n !== exp_stb) begin errors++; $display("FAIL %s stb_cycles got %0d exp %0d", name, stb_n, exp_stb); end
    checks++;
    if (lat !== exp_stb) begin errors++; $display("FAIL %s rsp_latency got %0d exp %0d", name, lat, exp_stb); end
    checks++;
    if (r_dat !== exp_dat) begin errors++; $display("FAIL %s rsp_dat got %h exp %h", name, r_dat, exp_dat); end
    checks++;
    if (r_err !== exp_err) begin errors++; $display("FAIL %s rsp_err got %b exp %b", name, r_err, exp_err); end
    checks++;
    if (bus_bad != 0) begin errors++; $display("FAIL %s bus_fields bad cycles got %0d exp 0", name, bus_bad); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL %s rsp_hold bad cycles got %0d exp 0", name, hold_bad); end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || stb !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake valid=%b ready=%b busy=%b stb=%b exp 0 1 0 0",
               name, rsp_valid, cmd_ready, busy, stb);
    end
    checks++;
    if (wbm_adr !== adr || wbm_dat !== dat || wbm_sel !== sel || wbm_we !== we) begin
      errors++;
      $display("FAIL %s retained_fields adr=%h dat=%h sel=%h we=%b exp %h %h %h %b",
               name, wbm_adr, wbm_dat, wbm_sel, wbm_we, adr, dat, sel, we);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (cyc !== 0 || stb !== 0 || wbm_we !== 0 || wbm_adr !== 0 || wbm_dat !== 0 ||
        wbm_sel !== 0 || rsp_valid !== 0 || rsp_dat !== 0 || rsp_err !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL reset_outputs cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rv=%b rd=%h re=%b busy=%b exp all 0",
               cyc, stb, wbm_we, wbm_adr, wbm_dat, wbm_sel, rsp_valid, rsp_dat, rsp_err, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    check_txn("write", 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h1111_2222, 0, 0, 0);
  endtask

  task automatic test_read();
    check_txn("read", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0, 0, 0);
  endtask

  task automatic test_timeout();
    check_txn("timeout", 1'b0, 32'h3000_0010, 32'h0, 4'h3, -1, 32'h5555_AAAA, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    check_txn("backpressure", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 5, 1, 0);
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h1234_5678; cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cyc !== 0 || stb !== 0 || busy !== 0 || wbm_adr !== 0) begin
      errors++;
      $display("FAIL reset_mid_bus cyc=%b stb=%b busy=%b adr=%h exp 0 0 0 0", cyc, stb, busy, wbm_adr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1 || busy !== 0 || rsp_valid !== 0 || cyc !== 0) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b rv=%b cyc=%b exp 1 0 0 0", cmd_ready, busy, rsp_valid, cyc);
    end
  endtask

  task automatic test_spurious_ack();
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      ack = 1'(i % 2 == 0);
      wbm_dat_i = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (cmd_ready !== 1 || busy !== 0 || rsp_valid !== 0 || stb !== 0) bad++;
    end
    ack = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_ack bad cycles got %0d exp 0", bad); end
    check_txn("resp_ack", 1'b0, 32'h3000_0050, 32'h0, 4'h1, 3, 32'h0BAD_C0DE, 4, 0, 1);
    check_txn("ack_on_timeout_edge", 1'b0, 32'h3000_0060, 32'h0, 4'hF, T - 1, 32'h7777_8888, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int w;
      w = int'($urandom_range(0, 11)) - 1;
      check_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom), w, $urandom,
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_spurious_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
